// File: rtl/regfile_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_pkg: shared types and sizing for the register file
// Revision: 1.0
// ------------------------------------------------------------------
package regfile_pkg;

  localparam int c_RF_DATA_W = 32;
  localparam int c_RF_DEPTH  = 32;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  // True when an address names a real, writable entry.
  function automatic logic rf_addr_live(input int unsigned addr,
                                        input int unsigned depth,
                                        input bit          zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_sb_if: decode/writeback-facing signal bundle of regfile_sb
// Revision: 1.0
// ------------------------------------------------------------------
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = c_RF_DATA_W,
  parameter int ADDR_W = $clog2(c_RF_DEPTH)
);

  logic              init_req;
  logic              init_busy;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] rd_a_addr;
  logic [ADDR_W-1:0] rd_b_addr;
  logic [DATA_W-1:0] rd_a_data;
  logic [DATA_W-1:0] rd_b_data;
  logic              busy_a;
  logic              busy_b;

  modport master (
    output init_req, wr_valid, wr_addr, wr_data, rsv_en, rsv_addr,
           rd_a_addr, rd_b_addr,
    input  init_busy, wr_ready, rd_a_data, rd_b_data, busy_a, busy_b
  );

  modport slave (
    input  init_req, wr_valid, wr_addr, wr_data, rsv_en, rsv_addr,
           rd_a_addr, rd_b_addr,
    output init_busy, wr_ready, rd_a_data, rd_b_data, busy_a, busy_b
  );

endinterface
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_rdport: one registered read port with bypass and scoreboard bit
// Revision: 1.0
// ------------------------------------------------------------------
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = c_RF_DATA_W,
  parameter int DEPTH    = c_RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              init_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_fire_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] mem_i [DEPTH],
  input  logic [DEPTH-1:0]  sb_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              w_live;

  // Out-of-range and hardwired-zero addresses both collapse to "0, not busy".
  assign w_live = rf_addr_live(32'(addr_i), DEPTH, ZERO_REG);

  always_comb begin
    data_d = '0;
    busy_d = 1'b0;
    if (!init_i && w_live) begin
      if (BYPASS && wr_fire_i && (wr_addr_i == addr_i)) begin
        data_d = wr_data_i;
      end else begin
        data_d = mem_i[addr_i];
        busy_d = sb_i[addr_i];
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_sb: 1W/2R register file with pending-write scoreboard and zeroing sweep
// Revision: 1.0
// ------------------------------------------------------------------
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = c_RF_DATA_W,
  parameter int DEPTH    = c_RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         clr_n,
  regfile_sb_if.slave bus
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DEPTH-1:0]  sb_q, sb_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic w_run;
  logic w_wr_fire;
  logic w_wr_live;
  logic w_rsv_live;

  assign w_run      = (state_q == RUN);
  assign w_wr_fire  = bus.wr_valid && w_run;
  assign w_wr_live  = w_wr_fire && rf_addr_live(32'(bus.wr_addr), DEPTH, ZERO_REG);
  assign w_rsv_live = bus.rsv_en && w_run
                      && rf_addr_live(32'(bus.rsv_addr), DEPTH, ZERO_REG);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      INIT: begin
        if (idx_q == c_LAST) begin
          state_d = RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.init_req) begin
          state_d = INIT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Reservation is applied after the write clear so a re-issued producer wins.
  always_comb begin
    sb_d = sb_q;
    if (w_run && bus.init_req) begin
      sb_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_live && (bus.wr_addr == ADDR_W'(i))) sb_d[i] = 1'b0;
        if (w_rsv_live && (bus.rsv_addr == ADDR_W'(i))) sb_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Storage has no reset; the sweep owns the write port while in INIT.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[idx_q] <= '0;
    end else if (w_wr_live) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.init_busy = (state_q == INIT);
  assign bus.wr_ready  = w_run;

  regfile_rdport #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd_a (
    .clk      (clk),
    .clr_n    (clr_n),
    .init_i   (!w_run),
    .addr_i   (bus.rd_a_addr),
    .wr_fire_i(w_wr_fire),
    .wr_addr_i(bus.wr_addr),
    .wr_data_i(bus.wr_data),
    .mem_i    (mem_q),
    .sb_i     (sb_q),
    .data_o   (bus.rd_a_data),
    .busy_o   (bus.busy_a)
  );

  regfile_rdport #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_rd_b (
    .clk      (clk),
    .clr_n    (clr_n),
    .init_i   (!w_run),
    .addr_i   (bus.rd_b_addr),
    .wr_fire_i(w_wr_fire),
    .wr_addr_i(bus.wr_addr),
    .wr_data_i(bus.wr_data),
    .mem_i    (mem_q),
    .sb_i     (sb_q),
    .data_o   (bus.rd_b_data),
    .busy_o   (bus.busy_b)
  );

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file: one write port, two read ports, configurable width and depth.
- Read data is registered, with optional write-to-read bypass and an optional hardwired-zero entry 0.
- Per-entry scoreboard of pending writes for hazard detection.
- Sequential zeroing sweep after reset or on request.
- Sits between the decode stage (reads, reservations) and the writeback stage (writes) of the datapath.

Parameters:
- DATA_W, 32, bits per entry.
- DEPTH, 32, number of entries (2..256, need not be a power of 2).
- ADDR_W, $clog2(DEPTH), address width.
- ZERO_REG, 1, entry 0 always reads 0 and ignores writes and reservations.
- BYPASS, 1, a read of the entry being written in the same cycle returns the new data.

Ports:
- clk, in, 1, clock, rising edge.
- clr_n, in, 1, asynchronous active-low reset.
- init_req, in, 1, single-cycle pulse; starts a zeroing sweep.
- init_busy, out, 1, high while the sweep runs.
- wr_valid, in, 1, write request.
- wr_ready, out, 1, write accepted when wr_valid && wr_ready.
- wr_addr, in, ADDR_W, write address.
- wr_data, in, DATA_W, write data.
- rsv_en, in, 1, mark rsv_addr as pending write.
- rsv_addr, in, ADDR_W, entry to reserve.
- rd_a_addr, in, ADDR_W, read port A address.
- rd_b_addr, in, ADDR_W, read port B address.
- rd_a_data, out, DATA_W, port A data, one cycle after the address.
- rd_b_data, out, DATA_W, port B data, one cycle after the address.
- busy_a, out, 1, scoreboard bit of rd_a_addr, aligned with rd_a_data.
- busy_b, out, 1, scoreboard bit of rd_b_addr, aligned with rd_b_data.

Behaviour:
- Reset (clr_n low, asynchronous):
  - rd_a_data, rd_b_data, busy_a, busy_b = 0.
  - All scoreboard bits = 0.
  - FSM = INIT, sweep index = 0.
  - init_busy = 1, wr_ready = 0.
  - The storage array has no reset; it is cleared by the sweep.
- FSM states INIT and RUN:
  - INIT: each cycle write 0 to entry idx, then idx++. When idx = DEPTH-1 is written, go to RUN next cycle. The sweep takes exactly DEPTH cycles.
  - RUN: init_req = 1 goes to INIT with idx = 0, and all scoreboard bits clear on the same edge.
  - init_req during INIT is ignored; the sweep does not restart.
- init_busy = (state == INIT); wr_ready = (state == RUN). Both are registered state decodes.
- Write: on fire, mem[wr_addr] <= wr_data at the clock edge, and scoreboard[wr_addr] <= 0.
- Read, per port, registered with latency 1. The next value is chosen in this priority order:
  1. State is INIT: data 0, busy 0.
  2. ZERO_REG and addr == 0: data 0, busy 0.
  3. addr >= DEPTH: data 0, busy 0.
  4. BYPASS, a write fires, and wr_addr == addr: data = wr_data, busy 0.
  5. Otherwise data = mem[addr], busy = scoreboard[addr].
  - With BYPASS = 0, case 4 returns the old mem value and the current scoreboard bit (read-before-write).
- Reservation: rsv_en in RUN sets scoreboard[rsv_addr] <= 1.
  - Ignored when in INIT, when rsv_addr >= DEPTH, or when ZERO_REG and rsv_addr == 0.
  - busy_x in the cycle after a reservation to the read address reflects the reservation (scoreboard read is registered after update: busy uses the post-edge value of the previous cycle). A reservation and a read of the same entry in the same cycle therefore give busy 0 for that read.
- Write with wr_addr >= DEPTH, or to entry 0 with ZERO_REG: accepted (handshake completes), no effect on storage or scoreboard.
- Simultaneous reserve and write to the same entry: reservation wins, scoreboard ends at 1, and mem still takes wr_data (a new producer is issued).
- Both read ports on the same address: identical results.
- Reset mid-sweep or mid-RUN: immediate return to the reset state and a full sweep restarts after clr_n rises.

Decomposition:
- Shared package regfile_pkg holds:
  - typedef rf_state_t {INIT, RUN};
  - localparam defaults for DATA_W and DEPTH, shared with the decode and writeback stages.
- One sub-module, regfile_rdport: address range check, zero-reg/bypass/mem mux and output registers. It is instantiated twice, for ports A and B.
- Storage, scoreboard and FSM stay in the top module.

Test Plan:
- Release clr_n, DEPTH=32 -> init_busy high for exactly 32 cycles, then wr_ready=1; every read returns 0 with busy 0.
- In RUN, write addr 5 = 0xDEADBEEF, then read A=5 next cycle -> rd_a_data = 0xDEADBEEF one cycle later.
- Write addr 7 = 0x12345678 while reading B=7 in the same cycle -> with BYPASS=1, rd_b_data = 0x12345678 next cycle; with BYPASS=0, the old value (0).
- Write addr 0 = 0xFFFFFFFF with ZERO_REG=1, then read A=0 and B=0 -> both 0; rsv_en on addr 0 -> busy stays 0.
- rsv_en addr 9, then read A=9 -> busy_a=1; write addr 9 = 0x55 -> next read gives busy_a=0, data 0x55. Reserve and write addr 9 in the same cycle -> busy_a=1 afterwards.
- In RUN with entries written and reserved, pulse init_req -> wr_ready=0 for DEPTH cycles, all data 0 and scoreboard cleared; clr_n low mid-sweep -> outputs 0 immediately and a full DEPTH-cycle sweep after release.
